// File: rtl/buffer_arbiter_pkg.sv
// Shared types and constants for buffer_arbiter: FSM state encoding,
// the write-counter width and a constant-evaluable clog2 helper.
package buffer_arbiter_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_WRITE = 1'b1
    } arb_state_e;

    localparam int COUNT_W = 16;

    // Never returns less than 1 so single-entry configurations keep a real index bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/buffer_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of eligible
// at or after ptr, searching modulo NREQ.
module rr_pick
    import buffer_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   winner
);

    int idx;

    // Scanning from the far end lets the closest candidate to ptr overwrite the rest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin write arbiter for a bank of channel hold-buffers.
// Define BUFFER_ARBITER_OVERWRITE_EN to drop the avail-based overwrite protection.
module buffer_arbiter
    import buffer_arbiter_pkg::*;
#(
    parameter int bitwidth = 24,
    parameter int NREQ     = 4,
    parameter int NCH      = 8,
    localparam int AW      = clog2(NCH),
    localparam int PW      = clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*bitwidth-1:0] req_data,
    input  logic [NCH-1:0]           avail,
    output logic [NREQ-1:0]          grant,
    output logic                     set_out,
    output logic [AW-1:0]            set_addr,
    output logic [bitwidth-1:0]      set_data,
    output logic [NREQ-1:0]          blocked,
    output logic                     addr_err,
    output logic [COUNT_W-1:0]       write_count
);

`ifdef BUFFER_ARBITER_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    localparam logic [AW:0] NCH_L = (AW + 1)'(NCH);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        win_q, win_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [bitwidth-1:0]  data_q, data_d;
    logic [NREQ-1:0]      blocked_q, blocked_d;
    logic                 addr_err_q, addr_err_d;
    logic [COUNT_W-1:0]   write_count_q, write_count_d;

    logic [NREQ-1:0]      eligible;
    logic [NREQ-1:0]      avail_hit;
    logic                 pick_found;
    logic [PW-1:0]        pick_idx;
    logic                 addr_ok;
    logic                 in_write;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic [AW-1:0] tgt;
            logic          in_range;
            assign tgt       = req_addr[gi*AW +: AW];
            assign in_range  = ({1'b0, tgt} < NCH_L);
            // Out-of-range targets have no avail bit, so they can never be held off.
            assign avail_hit[gi] = !OVERWRITE && in_range && avail[tgt];
            assign eligible[gi]  = req[gi] && enable && !avail_hit[gi];
            assign blocked_d[gi] = req[gi] && enable && avail_hit[gi];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .winner   (pick_idx)
    );

    assign addr_ok = ({1'b0, addr_q} < NCH_L);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        addr_d        = addr_q;
        data_d        = data_q;
        addr_err_d    = addr_err_q;
        write_count_d = write_count_q;
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    state_d = ST_WRITE;
                    win_d   = pick_idx;
                    addr_d  = req_addr[int'(pick_idx)*AW +: AW];
                    data_d  = req_data[int'(pick_idx)*bitwidth +: bitwidth];
                end
            end
            ST_WRITE: begin
                state_d = ST_ARB;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                if (addr_ok) begin
                    if (write_count_q != '1) begin
                        write_count_d = write_count_q + 1'b1;
                    end
                end else begin
                    addr_err_d = 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_ARB;
            ptr_q         <= '0;
            win_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            blocked_q     <= '0;
            addr_err_q    <= 1'b0;
            write_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            blocked_q     <= blocked_d;
            addr_err_q    <= addr_err_d;
            write_count_q <= write_count_d;
        end
    end

    // Reset masks the strobe within the cycle it is asserted so a dropped write never reaches the bank.
    assign in_write = (state_q == ST_WRITE) && !reset;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_grant
            assign grant[gi] = in_write && (win_q == PW'(gi));
        end
    endgenerate

    assign set_out     = in_write && addr_ok;
    assign set_addr    = addr_q;
    assign set_data    = data_q;
    assign blocked     = blocked_q;
    assign addr_err    = addr_err_q;
    assign write_count = write_count_q;

endmodule
